// File: rtl/domain_pwr_seq.sv
// Power sequencer for one switchable clock domain: orders PLL lock, clock enable and
// reset release on power-up, and reset assertion before clock gating on power-down.
module domain_pwr_seq #(
    parameter int LOCK_TIMEOUT = 1024,
    parameter int RST_HOLD_CYC = 16,
    parameter int CLK_OFF_CYC  = 4
) (
    input  logic       clk_i,
    input  logic       arst_ni,
    input  logic       enable_i,
    input  logic       pll_locked_i,
    output logic       clk_en_o,
    output logic       arst_n_o,
    output logic       ready_o,
    output logic       busy_o,
    output logic       timeout_o,
    output logic       lock_lost_o,
    output logic [2:0] state_o
);

    localparam int MAX_AB  = (LOCK_TIMEOUT > RST_HOLD_CYC) ? LOCK_TIMEOUT : RST_HOLD_CYC;
    localparam int CNT_MAX = (MAX_AB > CLK_OFF_CYC) ? MAX_AB : CLK_OFF_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(CLK_OFF_CYC - 1);

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_CLK_ON     = 3'd2,
        ST_RUN        = 3'd3,
        ST_RST_ASSERT = 3'd4,
        ST_CLK_OFF    = 3'd5,
        ST_ERR        = 3'd6
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timeout_reg, timeout_next;
    logic             lock_lost_reg, lock_lost_next;
    logic             clk_en_reg, clk_en_next;
    logic             arst_n_reg, arst_n_next;
    logic             ready_reg, ready_next;
    logic             busy_reg, busy_next;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_reg     <= ST_OFF;
            cnt_reg       <= '0;
            timeout_reg   <= 1'b0;
            lock_lost_reg <= 1'b0;
            clk_en_reg    <= 1'b0;
            arst_n_reg    <= 1'b0;
            ready_reg     <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            timeout_reg   <= timeout_next;
            lock_lost_reg <= lock_lost_next;
            clk_en_reg    <= clk_en_next;
            arst_n_reg    <= arst_n_next;
            ready_reg     <= ready_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        timeout_next   = timeout_reg;
        lock_lost_next = lock_lost_reg;
        clk_en_next    = 1'b0;
        arst_n_next    = 1'b0;
        ready_next     = 1'b0;
        busy_next      = 1'b0;

        case (state_reg)
            ST_OFF: begin
                if (enable_i) begin
                    state_next     = ST_WAIT_LOCK;
                    cnt_next       = '0;
                    timeout_next   = 1'b0;
                    lock_lost_next = 1'b0;
                end
            end
            ST_WAIT_LOCK: begin
                if (!enable_i) begin
                    state_next = ST_OFF;
                end else if (pll_locked_i) begin
                    state_next = ST_CLK_ON;
                    cnt_next   = '0;
                end else if (cnt_reg == LOCK_LAST) begin
                    state_next   = ST_ERR;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_CLK_ON: begin
                // Power-up runs to completion regardless of enable_i; only a lost
                // lock aborts it, straight into the orderly reset/gate sequence.
                if (!pll_locked_i) begin
                    state_next = ST_RST_ASSERT;
                    cnt_next   = '0;
                end else if (cnt_reg == HOLD_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable_i || !pll_locked_i) begin
                    state_next = ST_RST_ASSERT;
                    cnt_next   = '0;
                    if (!pll_locked_i) lock_lost_next = 1'b1;
                end
            end
            ST_RST_ASSERT: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = ST_CLK_OFF;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_CLK_OFF: begin
                if (cnt_reg == OFF_LAST) begin
                    state_next = ST_OFF;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_ERR: begin
                if (!enable_i) state_next = ST_OFF;
            end
            default: begin
                state_next = ST_OFF;
                cnt_next   = '0;
            end
        endcase

        // Outputs are decoded from the next state so every pin comes straight off a flop.
        case (state_next)
            ST_WAIT_LOCK:  busy_next = 1'b1;
            ST_CLK_ON: begin
                clk_en_next = 1'b1;
                busy_next   = 1'b1;
            end
            ST_RUN: begin
                clk_en_next = 1'b1;
                arst_n_next = 1'b1;
                ready_next  = 1'b1;
            end
            ST_RST_ASSERT: begin
                clk_en_next = 1'b1;
                busy_next   = 1'b1;
            end
            ST_CLK_OFF:    busy_next = 1'b1;
            default:       busy_next = 1'b0;
        endcase
    end

    assign clk_en_o    = clk_en_reg;
    assign arst_n_o    = arst_n_reg;
    assign ready_o     = ready_reg;
    assign busy_o      = busy_reg;
    assign timeout_o   = timeout_reg;
    assign lock_lost_o = lock_lost_reg;
    assign state_o     = state_reg;

endmodule

// File: tb/tb_domain_pwr_seq.sv
// Scoreboard bench for domain_pwr_seq: each queued item carries the inputs for one clock
// edge and the full output vector expected after it, derived from the documented timing.
module tb_domain_pwr_seq;

    localparam int LOCK_TIMEOUT = 8;
    localparam int RST_HOLD_CYC = 4;
    localparam int CLK_OFF_CYC  = 2;

    localparam logic [2:0] S_OFF  = 3'd0;
    localparam logic [2:0] S_WL   = 3'd1;
    localparam logic [2:0] S_CON  = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_RSTA = 3'd4;
    localparam logic [2:0] S_COFF = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    logic       clk_i = 1'b0;
    logic       arst_ni;
    logic       enable_i;
    logic       pll_locked_i;
    logic       clk_en_o;
    logic       arst_n_o;
    logic       ready_o;
    logic       busy_o;
    logic       timeout_o;
    logic       lock_lost_o;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic       en;
        logic       lock;
        logic [8:0] exp;
    } item_t;

    item_t exp_q[$];

    always #5 clk_i = ~clk_i;

    domain_pwr_seq #(
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .RST_HOLD_CYC(RST_HOLD_CYC),
        .CLK_OFF_CYC (CLK_OFF_CYC)
    ) dut (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .enable_i    (enable_i),
        .pll_locked_i(pll_locked_i),
        .clk_en_o    (clk_en_o),
        .arst_n_o    (arst_n_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o),
        .lock_lost_o (lock_lost_o),
        .state_o     (state_o)
    );

    // Output vector: {clk_en, arst_n, ready, busy, timeout, lock_lost, state[2:0]}
    function automatic logic [8:0] exp_vec(logic [2:0] st, logic to, logic ll);
        logic ce, rn, rd, bs;
        ce = 1'b0; rn = 1'b0; rd = 1'b0; bs = 1'b0;
        case (st)
            S_WL:    bs = 1'b1;
            S_CON:   begin ce = 1'b1; bs = 1'b1; end
            S_RUN:   begin ce = 1'b1; rn = 1'b1; rd = 1'b1; end
            S_RSTA:  begin ce = 1'b1; bs = 1'b1; end
            S_COFF:  bs = 1'b1;
            default: ;
        endcase
        return {ce, rn, rd, bs, to, ll, st};
    endfunction

    function automatic logic [8:0] obs_vec();
        return {clk_en_o, arst_n_o, ready_o, busy_o, timeout_o, lock_lost_o, state_o};
    endfunction

    task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b (ce,rn,rdy,bsy,to,ll,st)", tag, got, exp);
        end else begin
            $display("ok   %s out=%b", tag, got);
        end
    endtask

    task automatic push(input string tag, input logic en, input logic lock,
                        input logic [2:0] st, input logic to, input logic ll, input int n);
        item_t it;
        for (int i = 0; i < n; i++) begin
            it.tag  = $sformatf("%s[%0d]", tag, i);
            it.en   = en;
            it.lock = lock;
            it.exp  = exp_vec(st, to, ll);
            exp_q.push_back(it);
        end
    endtask

    task automatic drain();
        item_t it;
        while (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            enable_i     = it.en;
            pll_locked_i = it.lock;
            @(posedge clk_i);
            @(negedge clk_i);
            check_val(it.tag, obs_vec(), it.exp);
        end
    endtask

    task automatic push_power_up(input string tag);
        push({tag, "_wl"},  1'b1, 1'b1, S_WL,  1'b0, 1'b0, 1);
        push({tag, "_con"}, 1'b1, 1'b1, S_CON, 1'b0, 1'b0, RST_HOLD_CYC);
        push({tag, "_run"}, 1'b1, 1'b1, S_RUN, 1'b0, 1'b0, 1);
    endtask

    task automatic push_power_down(input string tag, input logic ll);
        push({tag, "_rsta"}, 1'b0, 1'b1, S_RSTA, 1'b0, ll, RST_HOLD_CYC);
        push({tag, "_coff"}, 1'b0, 1'b1, S_COFF, 1'b0, ll, CLK_OFF_CYC);
        push({tag, "_off"},  1'b0, 1'b1, S_OFF,  1'b0, ll, 1);
    endtask

    initial begin
        arst_ni      = 1'b0;
        enable_i     = 1'b0;
        pll_locked_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_val("reset_state", obs_vec(), 9'd0);
        arst_ni = 1'b1;

        // 1: power-up with lock already present
        push("idle", 1'b0, 1'b1, S_OFF, 1'b0, 1'b0, 1);
        push_power_up("up1");
        push("run1", 1'b1, 1'b1, S_RUN, 1'b0, 1'b0, 2);
        drain();

        // 2: orderly power-down
        push_power_down("dn2", 1'b0);
        drain();

        // 3: lock never arrives -> timeout, sticky flag, cleared on next request
        push("wl3",   1'b1, 1'b0, S_WL,  1'b0, 1'b0, LOCK_TIMEOUT);
        push("err3",  1'b1, 1'b0, S_ERR, 1'b1, 1'b0, 3);
        push("off3",  1'b0, 1'b0, S_OFF, 1'b1, 1'b0, 2);
        push("rewl3", 1'b1, 1'b0, S_WL,  1'b0, 1'b0, 1);
        push("back3", 1'b0, 1'b0, S_OFF, 1'b0, 1'b0, 1);
        drain();

        // 4: lock glitch in RUN -> lock_lost, full power-down, automatic re-request
        push_power_up("up4");
        push("drop4", 1'b1, 1'b0, S_RSTA, 1'b0, 1'b1, 1);
        push("rsta4", 1'b1, 1'b1, S_RSTA, 1'b0, 1'b1, RST_HOLD_CYC - 1);
        push("coff4", 1'b1, 1'b1, S_COFF, 1'b0, 1'b1, CLK_OFF_CYC);
        push("off4",  1'b1, 1'b1, S_OFF,  1'b0, 1'b1, 1);
        push_power_up("re4");
        drain();

        // 5: request withdrawn during CLK_ON -> RUN for one cycle, then power-down
        push_power_down("dn5a", 1'b0);
        push("wl5",   1'b1, 1'b1, S_WL,  1'b0, 1'b0, 1);
        push("con5a", 1'b1, 1'b1, S_CON, 1'b0, 1'b0, 1);
        push("con5b", 1'b0, 1'b1, S_CON, 1'b0, 1'b0, RST_HOLD_CYC - 1);
        push("run5",  1'b0, 1'b1, S_RUN, 1'b0, 1'b0, 1);
        push_power_down("dn5b", 1'b0);
        drain();

        // 6: asynchronous reset in RUN and in RST_ASSERT
        push_power_up("up6");
        drain();
        #2 arst_ni = 1'b0;
        #1 check_val("arst_in_run", obs_vec(), 9'd0);
        enable_i = 1'b0;
        #1 arst_ni = 1'b1;
        push("off6", 1'b0, 1'b1, S_OFF, 1'b0, 1'b0, 1);
        push_power_up("up6b");
        push("rsta6", 1'b0, 1'b1, S_RSTA, 1'b0, 1'b0, 2);
        drain();
        #2 arst_ni = 1'b0;
        #1 check_val("arst_in_rsta", obs_vec(), 9'd0);
        enable_i = 1'b0;
        #1 arst_ni = 1'b1;
        push("off6b", 1'b0, 1'b1, S_OFF, 1'b0, 1'b0, 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
